// File: rtl/reg_file.sv
// reg_file: a bank of DEPTH registers, each WIDTH bits wide.
// There is one write port with a per-bit write mask. There are two
// combinational read ports, and an optional same-cycle write-through bypass.
// A write to an address >= DEPTH is dropped, and werr is raised for one cycle.
module reg_file #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             werr
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             werr_q;
  logic             werr_d;
  logic             write_active;
  logic             waddr_ok;

  // A write with an all-zero mask changes nothing, so it is treated as no write at all.
  assign write_active = we && (wmask != '0);
  assign waddr_ok     = 32'(waddr) < DEPTH;

  // Next-state contents: merge masked write data into the addressed word.
  // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    mem_d  = mem_q;
    werr_d = write_active && !waddr_ok;
    for (int i = 0; i < DEPTH; i++) begin
      if (write_active && (32'(waddr) == i) && !(ZERO_REG0 && (i == 0))) begin
        mem_d[i] = (mem_q[i] & ~wmask) | (wdata & wmask);
      end
    end
  end

  // Read muxes. With bypass enabled, reads see the post-write word (mem_d).
  // This is suppressed during reset so rdata shows the stored contents until the clearing edge.
  // Unmatched (out-of-range) addresses fall through to 0.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (32'(raddr_a) == i) rdata_a = (BYPASS && !rst) ? mem_d[i] : mem_q[i];
      if (32'(raddr_b) == i) rdata_b = (BYPASS && !rst) ? mem_d[i] : mem_q[i];
    end
    if (ZERO_REG0 && (raddr_a == '0)) rdata_a = '0;
    if (ZERO_REG0 && (raddr_b == '0)) rdata_b = '0;
  end

  // State update. Synchronous reset takes priority over a write in the same cycle.
  // NOTE: the whole array is reset on purpose (every register must read 0 after reset).
  // That makes this bank flops rather than a RAM macro.
  // NOTE: non-blocking assignments here so all flops update together off the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      werr_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      werr_q <= werr_d;
    end
  end

  assign werr = werr_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file. Four instances share the same stimulus:
// default (bypass), no-bypass, zero-reg0, and DEPTH=6 for out-of-range addresses.
module tb_reg_file;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [2:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] wmask = '0;
  logic [2:0] raddr_a = '0;
  logic [2:0] raddr_b = '0;

  logic [7:0] a_byp, b_byp, a_nob, b_nob, a_z0, b_z0, a_oor, b_oor;
  logic       e_byp, e_nob, e_z0, e_oor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(1'b1), .ZERO_REG0(1'b0)) u_byp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(a_byp), .raddr_b(raddr_b), .rdata_b(b_byp), .werr(e_byp));

  reg_file #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(1'b0), .ZERO_REG0(1'b0)) u_nob (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(a_nob), .raddr_b(raddr_b), .rdata_b(b_nob), .werr(e_nob));

  reg_file #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(1'b1), .ZERO_REG0(1'b1)) u_z0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(a_z0), .raddr_b(raddr_b), .rdata_b(b_z0), .werr(e_z0));

  reg_file #(.WIDTH(8), .DEPTH(6), .AW(3), .BYPASS(1'b1), .ZERO_REG0(1'b0)) u_oor (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr_a(raddr_a), .rdata_a(a_oor), .raddr_b(raddr_b), .rdata_b(b_oor), .werr(e_oor));

  // Advance one rising edge, then settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [7:0] data, input logic [7:0] mask);
    we = 1'b1; waddr = addr; wdata = data; wmask = mask;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) write_reg(3'(i), 8'hA5, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i); #1;
      checks++;
      if (a_byp !== 8'hA5) begin errors++; $display("FAIL preload[%0d]: got %h expected a5", i, a_byp); end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(7 - i); #1;
      checks++;
      if (a_byp !== 8'h00 || b_byp !== 8'h00 || a_nob !== 8'h00 || b_nob !== 8'h00) begin
        errors++;
        $display("FAIL reset_clear[%0d]: got a=%h b=%h na=%h nb=%h expected 00", i, a_byp, b_byp, a_nob, b_nob);
      end
    end
    checks++;
    if ({e_byp, e_nob, e_z0, e_oor} !== 4'b0000) begin
      errors++; $display("FAIL reset_werr: got %b expected 0000", {e_byp, e_nob, e_z0, e_oor});
    end
  endtask

  task automatic test_masked_write();
    write_reg(3'd3, 8'hF0, 8'hFF);
    write_reg(3'd3, 8'h0F, 8'h3C);
    raddr_a = 3'd3; raddr_b = 3'd3; #1;
    checks++;
    if (a_byp !== 8'hCC || b_nob !== 8'hCC) begin
      errors++; $display("FAIL masked_write: got %h/%h expected cc", a_byp, b_nob);
    end
  endtask

  task automatic test_bypass();
    write_reg(3'd5, 8'h11, 8'hFF);
    we = 1'b1; waddr = 3'd5; wdata = 8'h77; wmask = 8'hFF; raddr_a = 3'd5; raddr_b = 3'd5; #1;
    checks++;
    if (a_byp !== 8'h77 || b_byp !== 8'h77) begin
      errors++; $display("FAIL bypass_same_cycle: got %h/%h expected 77", a_byp, b_byp);
    end
    checks++;
    if (a_nob !== 8'h11 || b_nob !== 8'h11) begin
      errors++; $display("FAIL nobypass_before: got %h/%h expected 11", a_nob, b_nob);
    end
    tick(); we = 1'b0; #1;
    checks++;
    if (a_nob !== 8'h77 || b_nob !== 8'h77) begin
      errors++; $display("FAIL nobypass_after: got %h/%h expected 77", a_nob, b_nob);
    end
    // Partial-mask bypass on port A while port B reads a different register.
    we = 1'b1; waddr = 3'd5; wdata = 8'h00; wmask = 8'h0F; raddr_a = 3'd5; raddr_b = 3'd3; #1;
    checks++;
    if (a_byp !== 8'h70 || b_byp !== 8'hCC || a_nob !== 8'h77) begin
      errors++; $display("FAIL partial_bypass: got a=%h b=%h na=%h expected 70 cc 77", a_byp, b_byp, a_nob);
    end
    tick(); we = 1'b0; #1;
    checks++;
    if (a_nob !== 8'h70) begin errors++; $display("FAIL partial_commit: got %h expected 70", a_nob); end
  endtask

  task automatic test_reset_vs_write();
    write_reg(3'd2, 8'h33, 8'hFF);
    rst = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'h55; wmask = 8'hFF; raddr_a = 3'd2; raddr_b = 3'd5; #1;
    checks++;
    if (a_byp !== 8'h33 || b_byp !== 8'h70) begin
      errors++; $display("FAIL bypass_in_reset: got %h/%h expected 33/70", a_byp, b_byp);
    end
    tick(); rst = 1'b0; we = 1'b0; #1;
    checks++;
    if (a_byp !== 8'h00 || a_nob !== 8'h00 || b_byp !== 8'h00) begin
      errors++; $display("FAIL reset_beats_write: got %h/%h/%h expected 00", a_byp, a_nob, b_byp);
    end
  endtask

  task automatic test_zero_reg0();
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; wmask = 8'hFF; raddr_a = 3'd0; raddr_b = 3'd0; #1;
    checks++;
    if (a_z0 !== 8'h00 || b_z0 !== 8'h00 || a_byp !== 8'hFF) begin
      errors++; $display("FAIL zero_reg0_before: got z=%h/%h byp=%h expected 00/00/ff", a_z0, b_z0, a_byp);
    end
    tick(); we = 1'b0; #1;
    checks++;
    if (a_z0 !== 8'h00 || b_z0 !== 8'h00 || a_byp !== 8'hFF || e_z0 !== 1'b0) begin
      errors++; $display("FAIL zero_reg0_after: got z=%h/%h byp=%h werr=%b expected 00/00/ff/0", a_z0, b_z0, a_byp, e_z0);
    end
    write_reg(3'd1, 8'h5A, 8'hFF);
    raddr_a = 3'd1; #1;
    checks++;
    if (a_z0 !== 8'h5A) begin errors++; $display("FAIL zero_reg0_reg1: got %h expected 5a", a_z0); end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp;
    for (int i = 0; i < 6; i++) write_reg(3'(i), 8'h10 + 8'(i), 8'hFF);
    checks++;
    if (e_oor !== 1'b0) begin errors++; $display("FAIL oor_werr_idle: got %b expected 0", e_oor); end
    write_reg(3'd7, 8'h99, 8'hFF);
    checks++;
    if (e_oor !== 1'b1 || e_byp !== 1'b0) begin
      errors++; $display("FAIL oor_werr_set: got %b (full-depth %b) expected 1 (0)", e_oor, e_byp);
    end
    for (int i = 0; i < 6; i++) begin
      raddr_a = 3'(i); raddr_b = 3'(i); exp = 8'h10 + 8'(i); #1;
      checks++;
      if (a_oor !== exp || b_oor !== exp) begin
        errors++; $display("FAIL oor_regs_kept[%0d]: got %h/%h expected %h", i, a_oor, b_oor, exp);
      end
    end
    raddr_a = 3'd7; raddr_b = 3'd6; #1;
    checks++;
    if (a_oor !== 8'h00 || b_oor !== 8'h00 || a_byp !== 8'h99) begin
      errors++; $display("FAIL oor_read: got %h/%h full-depth %h expected 00/00/99", a_oor, b_oor, a_byp);
    end
    tick();
    checks++;
    if (e_oor !== 1'b0) begin errors++; $display("FAIL oor_werr_clear: got %b expected 0", e_oor); end
    write_reg(3'd6, 8'h42, 8'h00);
    checks++;
    if (e_oor !== 1'b0) begin errors++; $display("FAIL oor_zero_mask: got %b expected 0", e_oor); end
  endtask

  task automatic test_back_to_back();
    write_reg(3'd6, 8'h01, 8'hFF);
    checks++;
    if (e_oor !== 1'b1) begin errors++; $display("FAIL b2b_werr_first: got %b expected 1", e_oor); end
    write_reg(3'd7, 8'h02, 8'hFF);
    checks++;
    if (e_oor !== 1'b1) begin errors++; $display("FAIL b2b_werr_second: got %b expected 1", e_oor); end
    write_reg(3'd4, 8'hE7, 8'hFF);
    raddr_a = 3'd4; raddr_b = 3'd6; #1;
    checks++;
    if (e_oor !== 1'b0 || a_oor !== 8'hE7 || b_byp !== 8'h01) begin
      errors++; $display("FAIL b2b_valid: got werr=%b a=%h b=%h expected 0 e7 01", e_oor, a_oor, b_byp);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_masked_write();
    test_bypass();
    test_reset_vs_write();
    test_zero_reg0();
    test_out_of_range();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parametrised register bank: the next generation of our 8-bit enable-latched register.
- Generalised to DEPTH words of WIDTH bits, edge-clocked instead of level-latched.
- One write port with per-bit write mask; two independent combinational read ports.
- Optional write-through bypass preserves the transparent-latch read behaviour.
- Sits between the datapath and the ALU as the general-purpose register store.

Parameters:
WIDTH, 8, bits per register word
DEPTH, 8, number of registers (2..256)
AW, 3, address width; must satisfy 2**AW >= DEPTH
BYPASS, 1, 1 = a read of the address being written returns the merged new value in the same cycle; 0 = reads return the stored value
ZERO_REG0, 0, 1 = register 0 is hardwired to all-zero and ignores writes

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
we  input  1  write enable, sampled at rising clk
waddr  input  AW  write address
wdata  input  WIDTH  write data
wmask  input  WIDTH  per-bit write mask; 1 = bit updated, 0 = bit retained
raddr_a  input  AW  read address, port A
rdata_a  output  WIDTH  read data, port A (combinational)
raddr_b  input  AW  read address, port B
rdata_b  output  WIDTH  read data, port B (combinational)
werr  output  1  registered flag: previous cycle attempted a write to an out-of-range address

Behaviour:
- Reset is synchronous and active-high: rst=1 at a rising clk edge clears every register to 0 and clears werr to 0.
- Reset has priority over a simultaneous write; that write is discarded.
- Rising edge with rst=0 and we=1: mem[waddr] <= (mem[waddr] & ~wmask) | (wdata & wmask).
- we=0: no register changes. wmask=0 with we=1: no change, and no werr.
- Read is combinational, zero latency: rdata_x = mem[raddr_x].
- Bypass, when BYPASS=1, we=1 and raddr_x == waddr (in range, not the zeroed reg0):
  - rdata_x = (mem[waddr] & ~wmask) | (wdata & wmask) in the same cycle.
  - Applies to each read port independently; both ports may bypass at once.
- BYPASS=0: a read returns the pre-write value until the edge commits; the new value is visible the following cycle.
- Bypass is suppressed while rst=1. rdata then shows the current stored contents; after the edge the contents are all 0.
- ZERO_REG0=1:
  - Reads of address 0 return 0 on both ports, including under bypass.
  - Writes to address 0 are ignored and do not set werr.
- Out-of-range addresses (>= DEPTH, possible when DEPTH < 2**AW):
  - A write is ignored and sets werr=1 on the next edge; werr is 0 on any edge without such a write.
  - A read returns 0.
- Two ports may read the same address. A write and two reads may all target one address in the same cycle.
- No other state; no internal FSM beyond storage and the werr flag.
- All outputs are defined out of reset: rdata reflects the cleared contents (0), werr=0.

Test Plan:
- Reset: write 0xA5 to all 8 regs, assert rst 1 cycle -> every rdata_a/rdata_b read returns 0x00; werr=0.
- Masked write: reg3=0xF0; write we=1, waddr=3, wdata=0x0F, wmask=0x3C -> after edge reg3 reads 0xCC.
- Bypass: BYPASS=1, reg5=0x11; same cycle we=1, waddr=5, wdata=0x77, wmask=0xFF, raddr_a=raddr_b=5 -> both rdata=0x77 before the edge. With BYPASS=0 -> 0x11 before the edge, 0x77 after.
- Reset vs write: rst=1 and we=1, waddr=2, wdata=0x55 in the same cycle -> reg2 reads 0x00 afterwards.
- ZERO_REG0=1: write 0xFF to addr 0 -> rdata at addr 0 = 0x00 both before and after the edge; werr=0.
- Out-of-range: DEPTH=6, AW=3; write addr 7, wdata=0x99 -> werr=1 for one cycle, regs 0..5 unchanged, read of addr 7 = 0x00; next idle cycle -> werr=0.
